if_id_skid_stage: RTL and testbench

- Parametrised IF/ID pipeline stage register. It replaces the fixed 32-bit hold/flush latch between fetch and decode.
- Adds a valid/ready handshake on both sides and a one-entry skid buffer, so fetch can be back-pressured without a combinational ready path.
- Flush takes priority over hold, and a flushed or drained stage outputs a configurable NOP.
- Saturating stall and flush event counters feed the performance monitor.

---
 rtl/if_id_skid_stage.sv | 126 ++++++++++++
 tb/tb_if_id_skid_stage.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/if_id_skid_stage.sv
// IF/ID pipeline register with valid/ready handshake and a one-entry skid buffer.
// Flush beats hold; empty or flushed stage drives NOP; saturating stall/flush counters.
module if_id_skid_stage #(
  parameter int                 INSTR_W   = 32,
  parameter int                 PC_W      = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = {INSTR_W{1'b0}},
  parameter int                 CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instrIn,
  input  logic [PC_W-1:0]    PCplus4,
  input  logic               hold,
  input  logic               IF_flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] instrOut,
  output logic [PC_W-1:0]    PCplus4Out,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  // bit0 = main entry valid, bit1 = skid entry valid
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } occ_e;

  occ_e               state, state_n;
  logic [INSTR_W-1:0] instr_q, instr_n;
  logic [PC_W-1:0]    pc_q, pc_n;
  logic [INSTR_W-1:0] skid_instr, skid_instr_n;
  logic [PC_W-1:0]    skid_pc, skid_pc_n;
  logic               skid_valid;
  logic               in_fire;
  logic               out_fire;
  logic               stall_ev;
  logic               flush_ev;

  assign out_valid  = state[0];
  assign skid_valid = state[1];
  assign in_ready   = ~state[1];
  assign instrOut   = instr_q;
  assign PCplus4Out = pc_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready & ~hold;
  assign stall_ev = out_valid & ~out_fire;
  assign flush_ev = IF_flush & (out_valid | skid_valid);

  always_comb begin
    state_n      = state;
    instr_n      = instr_q;
    pc_n         = pc_q;
    skid_instr_n = skid_instr;
    skid_pc_n    = skid_pc;
    if (IF_flush) begin
      state_n = EMPTY;
      instr_n = NOP_INSTR;
      pc_n    = PCplus4;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_fire) begin
            state_n = ONE;
            instr_n = instrIn;
            pc_n    = PCplus4;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            instr_n = instrIn;
            pc_n    = PCplus4;
          end else if (in_fire) begin
            state_n      = FULL;
            skid_instr_n = instrIn;
            skid_pc_n    = PCplus4;
          end else if (out_fire) begin
            state_n = EMPTY;
            instr_n = NOP_INSTR;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_n = ONE;
            instr_n = skid_instr;
            pc_n    = skid_pc;
          end
        end
        default: state_n = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= EMPTY;
      instr_q    <= NOP_INSTR;
      pc_q       <= '0;
      skid_instr <= '0;
      skid_pc    <= '0;
    end else begin
      state      <= state_n;
      instr_q    <= instr_n;
      pc_q       <= pc_n;
      skid_instr <= skid_instr_n;
      skid_pc    <= skid_pc_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_ev && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
      if (flush_ev && (flush_cnt != {CNT_W{1'b1}}))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Directed bench for if_id_skid_stage: streaming, skid, flush, async reset,
// and counter saturation on a CNT_W=4 twin instance.
module tb_if_id_skid_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instrIn;
  logic [31:0] PCplus4;
  logic        hold;
  logic        IF_flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instrOut;
  logic [31:0] PCplus4Out;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  logic        in_ready4;
  logic        out_valid4;
  logic [31:0] instrOut4;
  logic [31:0] PCplus4Out4;
  logic [3:0]  stall_cnt4;
  logic [3:0]  flush_cnt4;

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] A = 32'h0000_0013;
  localparam logic [31:0] B = 32'h00A0_0093;
  localparam logic [31:0] C = 32'h00B0_0113;
  localparam logic [31:0] D = 32'h0010_0193;

  always #5 clk = ~clk;

  if_id_skid_stage u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .instrIn(instrIn), .PCplus4(PCplus4),
    .hold(hold), .IF_flush(IF_flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .instrOut(instrOut), .PCplus4Out(PCplus4Out),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  if_id_skid_stage #(.CNT_W(4)) u_sat (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready4),
    .instrIn(instrIn), .PCplus4(PCplus4),
    .hold(hold), .IF_flush(IF_flush),
    .out_valid(out_valid4), .out_ready(out_ready),
    .instrOut(instrOut4), .PCplus4Out(PCplus4Out4),
    .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] i,
                       input logic [31:0] p);
    in_valid = v;
    instrIn  = i;
    PCplus4  = p;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    instrIn   = '0;
    PCplus4   = '0;
    hold      = 1'b0;
    IF_flush  = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_instr", instrOut, 32'd0);
    chk("rst_pc", PCplus4Out, 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    chk("rst_flush", 32'(flush_cnt), 32'd0);

    // streaming A, B, C back to back
    drive(1'b1, A, 32'h4);
    tick();
    chk("s_a_valid", 32'(out_valid), 32'd1);
    chk("s_a_instr", instrOut, A);
    chk("s_a_pc", PCplus4Out, 32'h4);
    drive(1'b1, B, 32'h8);
    tick();
    chk("s_b_instr", instrOut, B);
    chk("s_b_ready", 32'(in_ready), 32'd1);
    drive(1'b1, C, 32'hC);
    tick();
    chk("s_c_instr", instrOut, C);
    chk("s_c_pc", PCplus4Out, 32'hC);
    chk("s_c_ready", 32'(in_ready), 32'd1);
    drive(1'b0, 32'h0, 32'h0);
    tick();
    chk("s_drain_valid", 32'(out_valid), 32'd0);
    chk("s_drain_instr", instrOut, 32'd0);
    chk("s_drain_pc", PCplus4Out, 32'hC);
    chk("s_stall", 32'(stall_cnt), 32'd0);

    // skid under hold
    do_reset();
    drive(1'b1, A, 32'h4);
    tick();
    drive(1'b1, B, 32'h8);
    hold = 1'b1;
    tick();
    chk("h_ready0", 32'(in_ready), 32'd0);
    chk("h_instr1", instrOut, A);
    tick();
    chk("h_instr2", instrOut, A);
    tick();
    chk("h_instr3", instrOut, A);
    chk("h_stall", 32'(stall_cnt), 32'd3);
    hold = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    tick();
    chk("h_b_instr", instrOut, B);
    chk("h_b_pc", PCplus4Out, 32'h8);
    chk("h_b_ready", 32'(in_ready), 32'd1);
    chk("h_stall_keep", 32'(stall_cnt), 32'd3);
    tick();
    chk("h_empty", 32'(out_valid), 32'd0);

    // flush from FULL overrides hold and drops C
    do_reset();
    drive(1'b1, A, 32'h4);
    tick();
    drive(1'b1, B, 32'h8);
    hold = 1'b1;
    tick();
    chk("f_full", 32'(in_ready), 32'd0);
    drive(1'b1, C, 32'h20);
    IF_flush = 1'b1;
    tick();
    chk("f_valid", 32'(out_valid), 32'd0);
    chk("f_instr", instrOut, 32'd0);
    chk("f_pc", PCplus4Out, 32'h20);
    chk("f_ready", 32'(in_ready), 32'd1);
    chk("f_cnt", 32'(flush_cnt), 32'd1);
    chk("f_stall", 32'(stall_cnt), 32'd2);
    IF_flush = 1'b0;
    hold = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    tick();
    chk("f_no_c", 32'(out_valid), 32'd0);
    IF_flush = 1'b1;
    tick();
    chk("f_empty_cnt", 32'(flush_cnt), 32'd1);
    chk("f_empty_valid", 32'(out_valid), 32'd0);
    IF_flush = 1'b0;

    // asynchronous reset between edges while FULL
    do_reset();
    drive(1'b1, A, 32'h4);
    tick();
    drive(1'b1, B, 32'h8);
    hold = 1'b1;
    tick();
    drive(1'b0, 32'h0, 32'h0);
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_instr", instrOut, 32'd0);
    chk("ar_ready", 32'(in_ready), 32'd1);
    chk("ar_stall", 32'(stall_cnt), 32'd0);
    rst = 1'b0;
    hold = 1'b0;
    drive(1'b1, D, 32'h40);
    tick();
    chk("ar_d_valid", 32'(out_valid), 32'd1);
    chk("ar_d_instr", instrOut, D);
    chk("ar_d_pc", PCplus4Out, 32'h40);

    // stall counter saturation on the 4-bit twin
    do_reset();
    drive(1'b1, A, 32'h4);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    hold = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    chk("sat16_cnt4", 32'(stall_cnt4), 32'd15);
    for (int i = 0; i < 4; i++) tick();
    chk("sat20_cnt4", 32'(stall_cnt4), 32'd15);
    chk("sat20_cnt16", 32'(stall_cnt), 32'd20);
    chk("sat_instr", instrOut4, A);
    hold = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
